// File: rtl/spiflash_emu.sv
// SPI NOR flash target emulator: oversamples the SPI pads on clk, decodes
// read/fast-read/quad-read/JEDEC-ID/power commands and serves a preloaded byte array.
module spiflash_emu #(
   parameter int           ADDR_BITS   = 16,
   parameter int           DUMMY_FAST  = 8,
   parameter int           DUMMY_QUAD  = 8,
   parameter logic [23:0]  JEDEC_ID    = 24'hEF4016,
   parameter bit           ENABLE_QUAD = 1'b1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 spi_csb,
   input  logic                 spi_sclk,
   input  logic [3:0]           spi_io_in,
   output logic [3:0]           spi_io_out,
   output logic [3:0]           spi_io_oe,
   input  logic                 load_valid,
   input  logic [ADDR_BITS-1:0] load_addr,
   input  logic [7:0]           load_data,
   output logic                 powered_down
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_DUMMY  = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
   localparam logic [2:0] S_IGNORE = 3'd5;

   logic       csb_s1, csb_s2, csb_d;
   logic       sclk_s1, sclk_s2, sclk_d;
   logic [3:0] io_s1, io_s2;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         csb_s1  <= 1'b1;
         csb_s2  <= 1'b1;
         csb_d   <= 1'b1;
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_d  <= 1'b0;
         io_s1   <= 4'b0;
         io_s2   <= 4'b0;
      end else begin
         csb_s1  <= spi_csb;
         csb_s2  <= csb_s1;
         csb_d   <= csb_s2;
         sclk_s1 <= spi_sclk;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         io_s1   <= spi_io_in;
         io_s2   <= io_s1;
      end
   end

   logic csb_fall, csb_rise, sclk_rise, sclk_fall;
   assign csb_fall  = !csb_s2 &&  csb_d;
   assign csb_rise  =  csb_s2 && !csb_d;
   assign sclk_rise =  sclk_s2 && !sclk_d;
   assign sclk_fall = !sclk_s2 &&  sclk_d;

   // Backing array: the fetch reads the pre-write contents on an address collision.
   logic [7:0]           mem [2**ADDR_BITS];
   logic [7:0]           rd_data;
   logic [ADDR_BITS-1:0] rd_addr;
   logic                 fetch_reg;

   always_ff @(posedge clk) begin
      if (load_valid) mem[load_addr] <= load_data;
      if (fetch_reg)  rd_data <= mem[rd_addr];
   end

   logic [2:0]  state_reg;
   logic [7:0]  cnt_reg;
   logic [7:0]  cmd_reg;
   logic [22:0] addr_sh;
   logic [7:0]  dummy_reg;
   logic        quad_reg;
   logic        jedec_reg;
   logic [1:0]  jidx_reg;
   logic        pend_pd, pend_wake;

   logic [7:0]  cmd_next;
   logic [23:0] addr_next;
   logic [7:0]  cur_byte;
   logic        unused_bits;

   assign cmd_next    = {cmd_reg[6:0], io_s2[0]};
   assign addr_next   = {addr_sh, io_s2[0]};
   assign unused_bits = ^{io_s2[3:1], addr_next[23]};

   always_comb begin
      cur_byte = rd_data;
      if (jedec_reg) begin
         case (jidx_reg)
            2'd0:    cur_byte = JEDEC_ID[23:16];
            2'd1:    cur_byte = JEDEC_ID[15:8];
            default: cur_byte = JEDEC_ID[7:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= 8'd0;
         cmd_reg      <= 8'd0;
         addr_sh      <= 23'd0;
         rd_addr      <= '0;
         fetch_reg    <= 1'b0;
         dummy_reg    <= 8'd0;
         quad_reg     <= 1'b0;
         jedec_reg    <= 1'b0;
         jidx_reg     <= 2'd0;
         pend_pd      <= 1'b0;
         pend_wake    <= 1'b0;
         powered_down <= 1'b0;
         spi_io_out   <= 4'b0;
         spi_io_oe    <= 4'b0;
      end else begin
         fetch_reg <= 1'b0;
         if (csb_rise) begin
            state_reg <= S_IDLE;
            spi_io_oe <= 4'b0;
            pend_pd   <= 1'b0;
            pend_wake <= 1'b0;
            if (state_reg == S_IGNORE) begin
               if (pend_pd)        powered_down <= 1'b1;
               else if (pend_wake) powered_down <= 1'b0;
            end
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if (csb_fall) begin
                     state_reg <= S_CMD;
                     cnt_reg   <= 8'd0;
                  end
               end
               S_CMD: begin
                  if (sclk_rise) begin
                     cmd_reg <= cmd_next;
                     cnt_reg <= cnt_reg + 8'd1;
                     if (cnt_reg == 8'd7) begin
                        cnt_reg   <= 8'd0;
                        quad_reg  <= 1'b0;
                        jedec_reg <= 1'b0;
                        state_reg <= S_IGNORE;
                        // Only the wake-up command is honoured while powered down.
                        if (!powered_down || cmd_next == 8'hAB) begin
                           case (cmd_next)
                              8'h03: begin
                                 state_reg <= S_ADDR;
                                 dummy_reg <= 8'd0;
                              end
                              8'h0B: begin
                                 state_reg <= S_ADDR;
                                 dummy_reg <= 8'(DUMMY_FAST);
                              end
                              8'h6B: begin
                                 if (ENABLE_QUAD) begin
                                    state_reg <= S_ADDR;
                                    dummy_reg <= 8'(DUMMY_QUAD);
                                    quad_reg  <= 1'b1;
                                 end
                              end
                              8'h9F: begin
                                 state_reg <= S_DATA;
                                 jedec_reg <= 1'b1;
                                 jidx_reg  <= 2'd0;
                              end
                              8'hB9:   pend_pd   <= 1'b1;
                              8'hAB:   pend_wake <= 1'b1;
                              default: ;
                           endcase
                        end
                     end
                  end
               end
               S_ADDR: begin
                  if (sclk_rise) begin
                     addr_sh <= addr_next[22:0];
                     cnt_reg <= cnt_reg + 8'd1;
                     if (cnt_reg == 8'd23) begin
                        cnt_reg   <= 8'd0;
                        rd_addr   <= addr_next[ADDR_BITS-1:0];
                        fetch_reg <= 1'b1;
                        state_reg <= (dummy_reg == 8'd0) ? S_DATA : S_DUMMY;
                     end
                  end
               end
               S_DUMMY: begin
                  if (sclk_rise) begin
                     cnt_reg <= cnt_reg + 8'd1;
                     if (cnt_reg == dummy_reg - 8'd1) begin
                        cnt_reg   <= 8'd0;
                        state_reg <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (sclk_fall) begin
                     cnt_reg <= cnt_reg + 8'd1;
                     if (quad_reg) begin
                        spi_io_out <= cnt_reg[0] ? cur_byte[3:0] : cur_byte[7:4];
                        spi_io_oe  <= 4'b1111;
                     end else begin
                        spi_io_out[1] <= cur_byte[3'd7 - cnt_reg[2:0]];
                        spi_io_oe     <= 4'b0010;
                     end
                     // Byte boundary: advance and prefetch well ahead of the next fall.
                     if ((quad_reg && cnt_reg == 8'd1) || (!quad_reg && cnt_reg == 8'd7)) begin
                        cnt_reg <= 8'd0;
                        if (jedec_reg) begin
                           jidx_reg <= (jidx_reg == 2'd2) ? 2'd0 : jidx_reg + 2'd1;
                        end else begin
                           rd_addr   <= rd_addr + 1'b1;
                           fetch_reg <= 1'b1;
                        end
                     end
                  end
               end
               S_IGNORE: begin
                  // Extra clocks after a power command cancel it.
                  if (sclk_rise) begin
                     pend_pd   <= 1'b0;
                     pend_wake <= 1'b0;
                  end
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

endmodule
